// File: rtl/score_life_tracker.sv
// Score / lives tracker for a single-digit game display. Optional post-hit invulnerability
// window (state INVULN plus countdown timer) is built only when SCORE_LIFE_INVULN_EN is defined.
module score_life_tracker #(
    parameter int unsigned LIFE          = 3,
    parameter int unsigned MAX_SCORE     = 9,
    parameter int unsigned INVULN_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit_evt,
    input  logic       hited_evt,
    output logic [3:0] hit,
    output logic [3:0] hited,
    output logic       game_over,
    output logic       hurt_flash
);
    typedef enum logic [1:0] {StPlay, StInvuln, StOver} state_e;

    localparam logic [3:0] MaxScore = 4'(MAX_SCORE);
    localparam logic [3:0] Life     = 4'(LIFE);

    state_e     state_q, state_d;
    logic [3:0] hit_q, hit_d;
    logic [3:0] hited_q, hited_d;
    logic       game_over_q, game_over_d;
    logic [3:0] hit_sat;
    logic [3:0] hited_inc;

`ifdef SCORE_LIFE_INVULN_EN
    localparam int unsigned TimerW = 26;
    localparam logic [TimerW-1:0] TimerLoad = TimerW'(INVULN_CYCLES - 1);

    logic [TimerW-1:0] timer_q, timer_d;
    logic              hurt_flash_q, hurt_flash_d;
`endif

    // Score never wraps: it sticks at MaxScore.
    assign hit_sat   = (hit_evt && (hit_q < MaxScore)) ? hit_q + 4'd1 : hit_q;
    assign hited_inc = hited_q + 4'd1;

    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        hited_d = hited_q;
`ifdef SCORE_LIFE_INVULN_EN
        timer_d = timer_q;
`endif
        case (state_q)
            StOver: begin
                if (start) begin
                    hit_d   = 4'd0;
                    hited_d = 4'd0;
                    state_d = StPlay;
                end
            end
`ifdef SCORE_LIFE_INVULN_EN
            StInvuln: begin
                hit_d = hit_sat;
                // Leave on the cycle after the timer reads zero: INVULN_CYCLES cycles in total.
                if (timer_q == '0) begin
                    state_d = StPlay;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`endif
            default: begin
                hit_d = hit_sat;
                if (hited_evt) begin
                    hited_d = hited_inc;
                    if (hited_inc == Life) begin
                        state_d = StOver;
                    end
`ifdef SCORE_LIFE_INVULN_EN
                    else begin
                        state_d = StInvuln;
                        timer_d = TimerLoad;
                    end
`endif
                end
            end
        endcase
        game_over_d = (state_d == StOver);
`ifdef SCORE_LIFE_INVULN_EN
        hurt_flash_d = (state_d == StInvuln);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StPlay;
            hit_q        <= 4'd0;
            hited_q      <= 4'd0;
            game_over_q  <= 1'b0;
`ifdef SCORE_LIFE_INVULN_EN
            timer_q      <= '0;
            hurt_flash_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            hit_q        <= hit_d;
            hited_q      <= hited_d;
            game_over_q  <= game_over_d;
`ifdef SCORE_LIFE_INVULN_EN
            timer_q      <= timer_d;
            hurt_flash_q <= hurt_flash_d;
`endif
        end
    end

    assign hit       = hit_q;
    assign hited     = hited_q;
    assign game_over = game_over_q;
`ifdef SCORE_LIFE_INVULN_EN
    assign hurt_flash = hurt_flash_q;
`else
    assign hurt_flash = 1'b0;
`endif

endmodule

// File: tb/tb_score_life_tracker.sv
// Bench for score_life_tracker: directed scenarios with literal expectations plus a randomized
// run compared every cycle against an abstract game model. Adapts to SCORE_LIFE_INVULN_EN.
module tb_score_life_tracker;
    localparam int Life   = 3;
    localparam int MaxSc  = 9;
    localparam int Invuln = 4;
`ifdef SCORE_LIFE_INVULN_EN
    localparam bit InvulnEn = 1'b1;
`else
    localparam bit InvulnEn = 1'b0;
`endif

    logic       clk, rst, start, hit_evt, hited_evt;
    logic [3:0] hit, hited;
    logic       game_over, hurt_flash;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Abstract model: score, lives lost, game over flag, cycles of protection left.
    int m_score, m_lost, m_inv;
    bit m_over;

    score_life_tracker #(
        .LIFE          (Life),
        .MAX_SCORE     (MaxSc),
        .INVULN_CYCLES (Invuln)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .hit_evt    (hit_evt),
        .hited_evt  (hited_evt),
        .hit        (hit),
        .hited      (hited),
        .game_over  (game_over),
        .hurt_flash (hurt_flash)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst) begin
        int s, l, v;
        bit o;
        s = m_score; l = m_lost; v = m_inv; o = m_over;
        if (rst) begin
            s = 0; l = 0; v = 0; o = 1'b0;
        end else if (o) begin
            if (start) begin
                s = 0; l = 0; o = 1'b0;
            end
        end else begin
            if (hit_evt && s < MaxSc) s = s + 1;
            if (v > 0) begin
                v = v - 1;
            end else if (hited_evt) begin
                l = l + 1;
                if (l == Life) o = 1'b1;
                else if (InvulnEn) v = Invuln;
            end
        end
        m_score <= s; m_lost <= l; m_inv <= v; m_over <= o;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("model.hit", int'(hit), m_score);
            chk("model.hited", int'(hited), m_lost);
            chk("model.game_over", int'(game_over), int'(m_over));
            chk("model.hurt_flash", int'(hurt_flash), int'(m_inv > 0));
        end
    end

    // Drive one cycle of inputs from posedge+1; returns at posedge+1 after the sampling edge.
    task automatic cyc(input bit h, input bit hd, input bit st);
        hit_evt = h; hited_evt = hd; start = st;
        @(posedge clk);
        #1;
        hit_evt = 1'b0; hited_evt = 1'b0; start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hit_evt = 1'b0; hited_evt = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        hit_evt = 1'b0; hited_evt = 1'b0; start = 1'b0;
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("reset.hit", int'(hit), 0);
        chk("reset.hited", int'(hited), 0);
        chk("reset.game_over", int'(game_over), 0);
        chk("reset.hurt_flash", int'(hurt_flash), 0);

        // Score saturation.
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("sat.hit", int'(hit), (i < 9) ? i : 9);
        end

        // Hit, then second hit two cycles later.
        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        chk("inv.hited1", int'(hited), 1);
        chk("inv.flash_k", int'(hurt_flash), InvulnEn ? 1 : 0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("inv.hited2", int'(hited), InvulnEn ? 1 : 2);
        chk("inv.flash_k2", int'(hurt_flash), InvulnEn ? 1 : 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("inv.flash_k3", int'(hurt_flash), InvulnEn ? 1 : 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("inv.flash_k4", int'(hurt_flash), 0);
        chk("inv.hited_end", int'(hited), InvulnEn ? 1 : 2);

        // Three spaced hits end the game; later events are ignored.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            chk("over.hited", int'(hited), i);
            idle(9);
        end
        chk("over.game_over", int'(game_over), 1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("over.hit_hold", int'(hit), 0);
        chk("over.hited_hold", int'(hited), 3);

        // Restart from OVER, then start is ignored in PLAY.
        cyc(1'b0, 1'b0, 1'b1);
        chk("start.hit", int'(hit), 0);
        chk("start.hited", int'(hited), 0);
        chk("start.game_over", int'(game_over), 0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("start_play.hit", int'(hit), 1);
        chk("start_play.game_over", int'(game_over), 0);

        // Simultaneous score and final life lost.
        cyc(1'b0, 1'b1, 1'b0);
        idle(6);
        cyc(1'b0, 1'b1, 1'b0);
        idle(6);
        chk("simul.pre_hited", int'(hited), 2);
        cyc(1'b1, 1'b1, 1'b0);
        chk("simul.hit", int'(hit), 2);
        chk("simul.hited", int'(hited), 3);
        chk("simul.game_over", int'(game_over), 1);

        // Asynchronous reset in the middle of the invulnerability window.
        do_reset();
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.hit", int'(hit), 0);
        chk("arst.hited", int'(hited), 0);
        chk("arst.game_over", int'(game_over), 0);
        chk("arst.hurt_flash", int'(hurt_flash), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back hits.
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            chk("b2b.hited", int'(hited), InvulnEn ? 1 : i);
            chk("b2b.flash", int'(hurt_flash), InvulnEn ? 1 : 0);
        end
        chk("b2b.game_over", int'(game_over), InvulnEn ? 0 : 1);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                #2;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end else begin
                cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 7) == 0));
            end
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/score_life_tracker.md
SCORE_LIFE_TRACKER -- requirements
Module: score_life_tracker

Interface
REQ-001 The block SHALL have parameter LIFE, default 3, meaning player lives per game (1..15).
REQ-002 The block SHALL have parameter MAX_SCORE, default 9, meaning score saturation value, single display digit (0..15).
REQ-003 The block SHALL have parameter INVULN_CYCLES, default 50_000_000, meaning post-hit invulnerability length in clk cycles (1..2^26-1).
REQ-004 The block SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 The block SHALL have port start, input, 1, level; restarts the game when in OVER.
REQ-007 The block SHALL have port hit_evt, input, 1, one-cycle pulse: enemy destroyed by player.
REQ-008 The block SHALL have port hited_evt, input, 1, one-cycle pulse: player struck by enemy.
REQ-009 The block SHALL have port hit, output, 4, registered score, feeds the score digit of the display.
REQ-010 The block SHALL have port hited, output, 4, registered count of lives lost, feeds the life digit of the display.
REQ-011 The block SHALL have port game_over, output, 1, registered, high while in OVER.
REQ-012 The block SHALL have port hurt_flash, output, 1, registered, high while in INVULN.

Function
REQ-013 The block SHALL implement FSM states PLAY, INVULN and OVER; all outputs SHALL be registered, and each output SHALL change on the clk edge that samples the causing input (1-cycle latency).
REQ-014 In PLAY or INVULN, hit_evt SHALL increment hit by 1, saturating at MAX_SCORE; hit SHALL never wrap.
REQ-015 In PLAY, hited_evt SHALL increment hited by 1; if the new value equals LIFE, the FSM SHALL go to OVER and set game_over=1; otherwise it SHALL go to INVULN and load the timer with INVULN_CYCLES-1.
REQ-016 In INVULN, hited_evt SHALL be ignored, the timer SHALL decrement each cycle, and the FSM SHALL return to PLAY on the cycle after the timer reads 0, so INVULN lasts exactly INVULN_CYCLES cycles.
REQ-017 In OVER, hit_evt and hited_evt SHALL be ignored and hit/hited SHALL hold; start=1 SHALL clear hit and hited to 0, clear game_over, and enter PLAY on the next edge.
REQ-018 start SHALL be ignored in PLAY and INVULN.
REQ-019 Simultaneous hit_evt and hited_evt in PLAY SHALL both take effect in the same cycle, including the cycle that enters OVER.
REQ-020 hited SHALL never exceed LIFE, and LIFE-hited SHALL always be a valid remaining-lives value.

Reset
REQ-021 rst=1 SHALL immediately force state=PLAY, hit=0, hited=0, game_over=0, hurt_flash=0 and timer=0, from any state including mid-INVULN.
REQ-022 After rst deasserts, the first event SHALL be processed on the first rising clk edge.

Configuration
REQ-023 With macro SCORE_LIFE_INVULN_EN defined, INVULN and its timer SHALL exist as in REQ-015/016.
REQ-024 Without SCORE_LIFE_INVULN_EN, no timer SHALL be built, a non-final hited_evt SHALL keep the FSM in PLAY, hurt_flash SHALL be constant 0, and every hited_evt in PLAY SHALL count.

Verification (LIFE=3, MAX_SCORE=9, INVULN_CYCLES=4, macro defined unless noted)
REQ-025 The bench SHALL cover: 12 hit_evt pulses from reset -> hit steps 1..9, then stays 9.
REQ-026 The bench SHALL cover: hited_evt, then hited_evt 2 cycles later -> hited=1, hurt_flash high for exactly 4 cycles, second pulse ignored, hited stays 1.
REQ-027 The bench SHALL cover: 3 hited_evt pulses spaced 10 cycles -> hited=3 and game_over=1 on the third; later hit_evt leaves hit unchanged.
REQ-028 The bench SHALL cover: in OVER, start=1 for 1 cycle -> next cycle hit=0, hited=0, game_over=0; start pulsed in PLAY -> no change.
REQ-029 The bench SHALL cover: hit_evt and hited_evt in the same cycle with hited=2 -> hit+1 and hited=3, game_over=1 on the same edge.
REQ-030 The bench SHALL cover: rst asserted mid-INVULN -> outputs 0 without a clk edge; with macro undefined, 3 back-to-back hited_evt -> hited=1,2,3 on consecutive edges and hurt_flash always 0.
